// File: rtl/vec_cache_arbiter_pkg.sv
// Shared vector-cache types: cache op encodings, requester id type and
// the lane encoding used on every data path of the arbiter.
package vec_cache_arbiter_pkg;

  typedef enum logic [1:0] {
    VEC_DATA_READ_DISABLE = 2'd0,
    VEC_DATA_READ_VEC     = 2'd1,
    VEC_DATA_READ_LANE    = 2'd2
  } VecDataReadOp_t;

  typedef enum logic [1:0] {
    VEC_DATA_WRITE_DISABLE = 2'd0,
    VEC_DATA_WRITE_VEC     = 2'd1,
    VEC_DATA_WRITE_LANE    = 2'd2
  } VecDataWriteOp_t;

  // Default requester count: vector units, load/store engine, host DMA.
  localparam int VEC_NUM_REQ = 4;
  localparam int ID_SIZE     = $clog2(VEC_NUM_REQ);

  typedef logic [ID_SIZE-1:0] VecCacheReqId_t;

  // Each lane is a single-precision float carried as its IEEE-754 bit
  // pattern, so 0.0 is all-zero bits.
  localparam int LANE_BITS = 32;

endpackage

// File: rtl/vec_cache_arbiter_rr.sv
// Combinational round-robin arbiter: searches req starting at ptr and
// grants the first requester found (one-hot gnt plus its index).
module RoundRobinArbiter #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            gnt_valid
);

  int              sum;
  logic [ID_W-1:0] idx;

  // Walk the requesters in priority order ptr, ptr+1, ... and take the first one.
  always_comb begin
    gnt       = '0;
    gnt_id    = '0;
    gnt_valid = 1'b0;
    sum       = 0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      sum = (int'(ptr) + i) % N;
      idx = ID_W'(sum);
      if (!gnt_valid && req[idx]) begin
        gnt[idx]  = 1'b1;
        gnt_id    = idx;
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vec_cache_arbiter.sv
// Shares the vector cache's single read and single write port between
// NUM_REQ requesters with independent round-robin arbitration per port.
// A read to the entry being written this cycle is held off; read data is
// registered and returned one cycle after the grant, tagged with the id.
//
// Handshake: a requester raises *_req and keeps op/addr/param(/data) stable
// until *_gnt is seen; the transfer happens in the cycle req && gnt is high
// and a new request may follow in the next cycle. Grants are combinational.
// Responses have no back-pressure: requesters always accept them.
module vec_cache_arbiter
  import vec_cache_arbiter_pkg::VecDataReadOp_t,
         vec_cache_arbiter_pkg::VecDataWriteOp_t,
         vec_cache_arbiter_pkg::VEC_DATA_READ_DISABLE,
         vec_cache_arbiter_pkg::VEC_DATA_WRITE_DISABLE,
         vec_cache_arbiter_pkg::VEC_NUM_REQ,
         vec_cache_arbiter_pkg::LANE_BITS;
#(
  parameter int NUM_REQ         = VEC_NUM_REQ,
  parameter int ID_SIZE         = $clog2(NUM_REQ),
  parameter int WIDTH           = 128,
  parameter int WIDTH_ADDR_SIZE = $clog2(WIDTH),
  parameter int CACHE_SIZE      = 4,
  parameter int CACHE_ADDR_SIZE = $clog2(CACHE_SIZE)
) (
  input  logic                                              clock,
  input  logic                                              reset,
  // read requesters
  input  logic [NUM_REQ-1:0]                                rd_req,
  input  VecDataReadOp_t                                    rd_op [NUM_REQ],
  input  logic [NUM_REQ-1:0][CACHE_ADDR_SIZE-1:0]           rd_addr,
  input  logic [NUM_REQ-1:0][WIDTH_ADDR_SIZE-1:0]           rd_param,
  output logic [NUM_REQ-1:0]                                rd_gnt,
  output logic                                              rd_resp_valid,
  output logic [ID_SIZE-1:0]                                rd_resp_id,
  output logic [WIDTH-1:0][LANE_BITS-1:0]                   rd_resp_data,
  // write requesters
  input  logic [NUM_REQ-1:0]                                wr_req,
  input  VecDataWriteOp_t                                   wr_op [NUM_REQ],
  input  logic [NUM_REQ-1:0][CACHE_ADDR_SIZE-1:0]           wr_addr,
  input  logic [NUM_REQ-1:0][WIDTH_ADDR_SIZE-1:0]           wr_param,
  input  logic [NUM_REQ-1:0][WIDTH-1:0][LANE_BITS-1:0]      wr_data,
  output logic [NUM_REQ-1:0]                                wr_gnt,
  // cache side
  output VecDataReadOp_t                                    cache_read_op,
  output logic [CACHE_ADDR_SIZE-1:0]                        cache_read_addr,
  output logic [WIDTH_ADDR_SIZE-1:0]                        cache_read_param,
  output VecDataWriteOp_t                                   cache_write_op,
  output logic [CACHE_ADDR_SIZE-1:0]                        cache_write_addr,
  output logic [WIDTH_ADDR_SIZE-1:0]                        cache_write_param,
  output logic [WIDTH-1:0][LANE_BITS-1:0]                   cache_data_in,
  input  logic [WIDTH-1:0][LANE_BITS-1:0]                   cache_data_out
);

  logic [ID_SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [ID_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic               rd_resp_valid_q, rd_resp_valid_d;
  logic [ID_SIZE-1:0] rd_resp_id_q, rd_resp_id_d;
  logic [WIDTH-1:0][LANE_BITS-1:0] rd_resp_data_q, rd_resp_data_d;

  logic [NUM_REQ-1:0] wr_req_live, rd_req_live, rd_conflict;
  logic [ID_SIZE-1:0] wr_gnt_id, rd_gnt_id;
  logic               wr_gnt_valid, rd_gnt_valid;

  // Nothing is granted while reset is held, so the cache sees DISABLE ops.
  assign wr_req_live = wr_req & {NUM_REQ{~reset}};
  assign rd_req_live = rd_req & ~rd_conflict & {NUM_REQ{~reset}};

  RoundRobinArbiter #(.N(NUM_REQ), .ID_W(ID_SIZE)) u_wr_arb (
    .req       (wr_req_live),
    .ptr       (wr_ptr_q),
    .gnt       (wr_gnt),
    .gnt_id    (wr_gnt_id),
    .gnt_valid (wr_gnt_valid)
  );

  // Steer the granted writer onto the cache write port.
  always_comb begin
    cache_write_op    = VEC_DATA_WRITE_DISABLE;
    cache_write_addr  = '0;
    cache_write_param = '0;
    cache_data_in     = '0;
    if (wr_gnt_valid) begin
      cache_write_op    = wr_op[wr_gnt_id];
      cache_write_addr  = wr_addr[wr_gnt_id];
      cache_write_param = wr_param[wr_gnt_id];
      cache_data_in     = wr_data[wr_gnt_id];
    end
  end

  // A reader targeting the entry being written this cycle sits out; the
  // write wins and the reader keeps its priority for the next cycle.
  always_comb begin
    rd_conflict = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rd_conflict[i] = wr_gnt_valid && (rd_addr[i] == cache_write_addr);
    end
  end

  RoundRobinArbiter #(.N(NUM_REQ), .ID_W(ID_SIZE)) u_rd_arb (
    .req       (rd_req_live),
    .ptr       (rd_ptr_q),
    .gnt       (rd_gnt),
    .gnt_id    (rd_gnt_id),
    .gnt_valid (rd_gnt_valid)
  );

  // Steer the granted reader onto the cache read port.
  always_comb begin
    cache_read_op    = VEC_DATA_READ_DISABLE;
    cache_read_addr  = '0;
    cache_read_param = '0;
    if (rd_gnt_valid) begin
      cache_read_op    = rd_op[rd_gnt_id];
      cache_read_addr  = rd_addr[rd_gnt_id];
      cache_read_param = rd_param[rd_gnt_id];
    end
  end

  // Next-state: pointers move past the winner only on a grant; the response
  // captures cache data (forced to 0.0 for a DISABLE read) and the winner id.
  always_comb begin
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    rd_resp_valid_d = rd_gnt_valid;
    rd_resp_id_d    = rd_resp_id_q;
    rd_resp_data_d  = rd_resp_data_q;
    if (wr_gnt_valid) begin
      wr_ptr_d = (wr_gnt_id == ID_SIZE'(NUM_REQ - 1)) ? '0 : wr_gnt_id + 1'b1;
    end
    if (rd_gnt_valid) begin
      rd_ptr_d     = (rd_gnt_id == ID_SIZE'(NUM_REQ - 1)) ? '0 : rd_gnt_id + 1'b1;
      rd_resp_id_d = rd_gnt_id;
      rd_resp_data_d = (cache_read_op == VEC_DATA_READ_DISABLE) ? '0 : cache_data_out;
    end
  end

  // State registers; reset also drops any response still in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      rd_resp_valid_q <= 1'b0;
      rd_resp_id_q    <= '0;
      rd_resp_data_q  <= '0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      rd_resp_valid_q <= rd_resp_valid_d;
      rd_resp_id_q    <= rd_resp_id_d;
      rd_resp_data_q  <= rd_resp_data_d;
    end
  end

  assign rd_resp_valid = rd_resp_valid_q;
  assign rd_resp_id    = rd_resp_id_q;
  assign rd_resp_data  = rd_resp_data_q;

endmodule

// File: tb/tb_vec_cache_arbiter.sv
// Directed bench for vec_cache_arbiter with a small behavioural cache.
module tb_vec_cache_arbiter;
  import vec_cache_arbiter_pkg::*;

  localparam int NR  = 4;
  localparam int IDW = 2;
  localparam int W   = 8;
  localparam int WA  = 3;
  localparam int CS  = 4;
  localparam int CA  = 2;
  localparam int VB  = W * LANE_BITS;

  logic clock, reset;
  logic [NR-1:0]                          rd_req;
  VecDataReadOp_t                         rd_op [NR];
  logic [NR-1:0][CA-1:0]                  rd_addr;
  logic [NR-1:0][WA-1:0]                  rd_param;
  logic [NR-1:0]                          rd_gnt;
  logic                                   rd_resp_valid;
  logic [IDW-1:0]                         rd_resp_id;
  logic [W-1:0][LANE_BITS-1:0]            rd_resp_data;
  logic [NR-1:0]                          wr_req;
  VecDataWriteOp_t                        wr_op [NR];
  logic [NR-1:0][CA-1:0]                  wr_addr;
  logic [NR-1:0][WA-1:0]                  wr_param;
  logic [NR-1:0][W-1:0][LANE_BITS-1:0]    wr_data;
  logic [NR-1:0]                          wr_gnt;
  VecDataReadOp_t                         cache_read_op;
  logic [CA-1:0]                          cache_read_addr;
  logic [WA-1:0]                          cache_read_param;
  VecDataWriteOp_t                        cache_write_op;
  logic [CA-1:0]                          cache_write_addr;
  logic [WA-1:0]                          cache_write_param;
  logic [W-1:0][LANE_BITS-1:0]            cache_data_in;
  logic [W-1:0][LANE_BITS-1:0]            cache_data_out;

  int n_assert;
  int n_fail;

  vec_cache_arbiter #(
    .NUM_REQ(NR), .ID_SIZE(IDW), .WIDTH(W), .WIDTH_ADDR_SIZE(WA),
    .CACHE_SIZE(CS), .CACHE_ADDR_SIZE(CA)
  ) dut (
    .clock(clock), .reset(reset),
    .rd_req(rd_req), .rd_op(rd_op), .rd_addr(rd_addr), .rd_param(rd_param),
    .rd_gnt(rd_gnt), .rd_resp_valid(rd_resp_valid), .rd_resp_id(rd_resp_id),
    .rd_resp_data(rd_resp_data),
    .wr_req(wr_req), .wr_op(wr_op), .wr_addr(wr_addr), .wr_param(wr_param),
    .wr_data(wr_data), .wr_gnt(wr_gnt),
    .cache_read_op(cache_read_op), .cache_read_addr(cache_read_addr),
    .cache_read_param(cache_read_param),
    .cache_write_op(cache_write_op), .cache_write_addr(cache_write_addr),
    .cache_write_param(cache_write_param), .cache_data_in(cache_data_in),
    .cache_data_out(cache_data_out)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference vectors ----------------
  function automatic logic [W-1:0][LANE_BITS-1:0] init_vec(input int e);
    logic [W-1:0][LANE_BITS-1:0] v;
    for (int l = 0; l < W; l++) v[l] = {8'h40, 8'(e), 8'h00, 8'(l)};
    return v;
  endfunction

  function automatic logic [W-1:0][LANE_BITS-1:0] wr_vec(input int tag);
    logic [W-1:0][LANE_BITS-1:0] v;
    for (int l = 0; l < W; l++) v[l] = {8'hA5, 8'(tag), 8'h11, 8'(l)};
    return v;
  endfunction

  // ---------------- behavioural cache ----------------
  logic [W-1:0][LANE_BITS-1:0] mem [CS];
  assign cache_data_out = mem[cache_read_addr];

  always @(posedge clock) begin
    if (reset) begin
      for (int e = 0; e < CS; e++) mem[e] <= init_vec(e);
    end else if (cache_write_op == VEC_DATA_WRITE_VEC) begin
      mem[cache_write_addr] <= cache_data_in;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_reqs();
    rd_req   = '0;
    rd_addr  = '0;
    rd_param = '0;
    wr_req   = '0;
    wr_addr  = '0;
    wr_param = '0;
    wr_data  = '0;
    for (int i = 0; i < NR; i++) begin
      rd_op[i] = VEC_DATA_READ_VEC;
      wr_op[i] = VEC_DATA_WRITE_VEC;
    end
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [VB-1:0] obs, input logic [VB-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_assert = 0;
    n_fail   = 0;
    clear_reqs();
    reset  = 1'b1;
    rd_req = '1;
    wr_req = '1;

    // Reset: no grants, DISABLE ops, cleared response.
    #2;
    check("rst_rd_gnt", rd_gnt, 0);
    check("rst_wr_gnt", wr_gnt, 0);
    check("rst_rd_op", cache_read_op, VEC_DATA_READ_DISABLE);
    check("rst_wr_op", cache_write_op, VEC_DATA_WRITE_DISABLE);
    tick();
    tick();
    check("rst_valid", rd_resp_valid, 0);
    check("rst_id", rd_resp_id, 0);
    check("rst_data", rd_resp_data, 0);
    clear_reqs();
    reset = 1'b0;

    // Single read: requester 2, entry 1.
    rd_req[2]   = 1'b1;
    rd_addr[2]  = 2'd1;
    rd_param[2] = 3'd5;
    #3;
    check("t1_rd_gnt", rd_gnt, 4'b0100);
    check("t1_rd_addr", cache_read_addr, 2'd1);
    check("t1_rd_param", cache_read_param, 3'd5);
    check("t1_rd_op", cache_read_op, VEC_DATA_READ_VEC);
    tick();
    rd_req[2] = 1'b0;
    check("t1_valid", rd_resp_valid, 1);
    check("t1_id", rd_resp_id, 2);
    check("t1_data", rd_resp_data, init_vec(1));
    tick();
    check("t1_valid_once", rd_resp_valid, 0);

    // Reset with a read granted: response dropped, pointers cleared.
    rd_req[1]  = 1'b1;
    rd_addr[1] = 2'd2;
    #3;
    check("mr_rd_gnt", rd_gnt, 4'b0010);
    reset = 1'b1;
    #1;
    check("mr_gnt_in_rst", rd_gnt, 0);
    tick();
    check("mr_valid", rd_resp_valid, 0);
    check("mr_id", rd_resp_id, 0);
    check("mr_data", rd_resp_data, 0);
    clear_reqs();
    reset = 1'b0;
    tick();
    check("mr_valid_after", rd_resp_valid, 0);

    // All four read distinct entries: order 0,1,2,3,0,1,2,3 from a reset pointer.
    for (int i = 0; i < NR; i++) begin
      rd_req[i]  = 1'b1;
      rd_addr[i] = CA'(i);
    end
    for (int k = 0; k < 8; k++) begin
      #3;
      check($sformatf("rr_gnt%0d", k), rd_gnt, 1 << (k % 4));
      tick();
      check($sformatf("rr_valid%0d", k), rd_resp_valid, 1);
      check($sformatf("rr_id%0d", k), rd_resp_id, k % 4);
      check($sformatf("rr_data%0d", k), rd_resp_data, init_vec(k % 4));
    end
    clear_reqs();
    tick();
    check("rr_valid_end", rd_resp_valid, 0);

    // Same-entry conflict: write 0 -> entry 3 beats read 1 -> entry 3.
    wr_req[0]  = 1'b1;
    wr_addr[0] = 2'd3;
    wr_data[0] = wr_vec(3);
    rd_req[1]  = 1'b1;
    rd_addr[1] = 2'd3;
    #3;
    check("cf_wr_gnt", wr_gnt, 4'b0001);
    check("cf_rd_gnt", rd_gnt, 4'b0000);
    check("cf_wr_addr", cache_write_addr, 2'd3);
    check("cf_wr_op", cache_write_op, VEC_DATA_WRITE_VEC);
    check("cf_data_in", cache_data_in, wr_vec(3));
    check("cf_rd_op", cache_read_op, VEC_DATA_READ_DISABLE);
    tick();
    wr_req[0] = 1'b0;
    check("cf_no_resp", rd_resp_valid, 0);
    #3;
    check("cf_rd_gnt2", rd_gnt, 4'b0010);
    tick();
    rd_req[1] = 1'b0;
    check("cf_valid", rd_resp_valid, 1);
    check("cf_id", rd_resp_id, 1);
    check("cf_data", rd_resp_data, wr_vec(3));

    // Different entries in one cycle: both granted, read sees old data.
    wr_req[0]  = 1'b1;
    wr_addr[0] = 2'd0;
    wr_data[0] = wr_vec(0);
    rd_req[1]  = 1'b1;
    rd_addr[1] = 2'd2;
    #3;
    check("par_wr_gnt", wr_gnt, 4'b0001);
    check("par_rd_gnt", rd_gnt, 4'b0010);
    tick();
    clear_reqs();
    check("par_valid", rd_resp_valid, 1);
    check("par_id", rd_resp_id, 1);
    check("par_data", rd_resp_data, init_vec(2));

    // Read back entry 0 written above.
    rd_req[1]  = 1'b1;
    rd_addr[1] = 2'd0;
    #3;
    check("rb_rd_gnt", rd_gnt, 4'b0010);
    tick();
    clear_reqs();
    check("rb_data", rd_resp_data, wr_vec(0));

    // DISABLE read from requester 3: granted, zero data.
    rd_req[3]  = 1'b1;
    rd_addr[3] = 2'd1;
    rd_op[3]   = VEC_DATA_READ_DISABLE;
    #3;
    check("dis_gnt", rd_gnt, 4'b1000);
    check("dis_op", cache_read_op, VEC_DATA_READ_DISABLE);
    tick();
    clear_reqs();
    check("dis_valid", rd_resp_valid, 1);
    check("dis_id", rd_resp_id, 3);
    check("dis_data", rd_resp_data, 0);

    // Write round-robin: pointer sits at 1 after requester 0's last write.
    wr_req     = 4'b0011;
    wr_addr[0] = 2'd1;
    wr_addr[1] = 2'd2;
    wr_data[0] = wr_vec(10);
    wr_data[1] = wr_vec(11);
    #3;
    check("wrr_gnt1", wr_gnt, 4'b0010);
    check("wrr_addr1", cache_write_addr, 2'd2);
    check("wrr_data1", cache_data_in, wr_vec(11));
    tick();
    wr_req[1] = 1'b0;
    #3;
    check("wrr_gnt2", wr_gnt, 4'b0001);
    check("wrr_addr2", cache_write_addr, 2'd1);
    tick();
    clear_reqs();
    #3;
    check("idle_wr_op", cache_write_op, VEC_DATA_WRITE_DISABLE);
    check("idle_rd_op", cache_read_op, VEC_DATA_READ_DISABLE);
    check("idle_wr_gnt", wr_gnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
